// File: rtl/rdma_rx_pkg.sv
// Shared types and constants for the RDMA RX write path: opcodes, scheduler
// states and the DataMover S2MM command/status bit layout.
package rdma_rx_pkg;

    localparam logic [7:0] OP_WRITE_TEST = 8'h01;
    localparam logic [7:0] OP_WRITE_ONLY = 8'h0A;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CMD  = 3'd1,
        DATA = 3'd2,
        DROP = 3'd3,
        STS  = 3'd4
    } state_t;

    // S2MM command word: {rsvd, tag, saddr, drr, eof, dsa, incr, btt}
    localparam int CMD_WIDTH      = 72;
    localparam int CMD_BTT_LSB    = 0;
    localparam int CMD_BTT_WIDTH  = 23;
    localparam int CMD_INCR_BIT   = 23;
    localparam int CMD_DSA_LSB    = 24;
    localparam int CMD_EOF_BIT    = 30;
    localparam int CMD_DRR_BIT    = 31;
    localparam int CMD_SADDR_LSB  = 32;
    localparam int CMD_TAG_LSB    = 64;
    localparam int CMD_RSVD_LSB   = 68;

    // S2MM status byte
    localparam int STS_TAG_LSB    = 0;
    localparam int STS_INTERR_BIT = 4;
    localparam int STS_DECERR_BIT = 5;
    localparam int STS_SLVERR_BIT = 6;
    localparam int STS_OKAY_BIT   = 7;

    function automatic logic [CMD_WIDTH-1:0] s2mm_cmd(
        input logic [3:0]               tag,
        input logic [31:0]              saddr,
        input logic [CMD_BTT_WIDTH-1:0] btt
    );
        logic [CMD_WIDTH-1:0] c;
        c                               = '0;
        c[CMD_TAG_LSB +: 4]             = tag;
        c[CMD_SADDR_LSB +: 32]          = saddr;
        c[CMD_DRR_BIT]                  = 1'b0;
        c[CMD_EOF_BIT]                  = 1'b1;
        c[CMD_DSA_LSB +: 6]             = 6'h0;
        c[CMD_INCR_BIT]                 = 1'b1;
        c[CMD_BTT_LSB +: CMD_BTT_WIDTH] = btt;
        return c;
    endfunction

    function automatic logic sts_is_ok(input logic [7:0] sts);
        return sts[STS_OKAY_BIT] && !sts[STS_SLVERR_BIT]
            && !sts[STS_DECERR_BIT] && !sts[STS_INTERR_BIT];
    endfunction

endpackage

// File: rtl/rx_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module rx_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge aclk) begin
        if (areset) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {WIDTH{1'b1}})) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/rx_dma_write_scheduler.sv
// Turns parsed RDMA write headers into DataMover S2MM commands, forwards or
// drops the payload, and tracks status. Optional PSN ordering check: RX_PSN_CHECK_EN.
module rx_dma_write_scheduler
    import rdma_rx_pkg::*;
#(
    parameter int C_AXIS_TDATA_WIDTH = 32,
    parameter int C_AXIS_TKEEP_WIDTH = 4,
    parameter int BTT_WIDTH          = 23
) (
    input  logic                          aclk,
    input  logic                          areset,

    input  logic                          header_valid,
    input  logic [7:0]                    rdma_opcode,
    input  logic [23:0]                   rdma_psn,
    input  logic [31:0]                   rdma_remote_addr,
    input  logic [15:0]                   fragment_offset,
    input  logic [31:0]                   rdma_length,

    input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic [C_AXIS_TKEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                          s_axis_tvalid,
    input  logic                          s_axis_tlast,
    output logic                          s_axis_tready,

    output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic [C_AXIS_TKEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    input  logic                          m_axis_tready,

    output logic [71:0]                   m_axis_cmd_tdata,
    output logic                          m_axis_cmd_tvalid,
    input  logic                          m_axis_cmd_tready,

    input  logic [7:0]                    s_axis_sts_tdata,
    input  logic                          s_axis_sts_tvalid,
    output logic                          s_axis_sts_tready,

    output logic                          busy,
    output logic [23:0]                   expected_psn,
    output logic [15:0]                   pkt_ok_cnt,
    output logic [15:0]                   pkt_drop_cnt,
    output logic [15:0]                   dma_err_cnt,
    output logic                          hdr_overrun
);

    localparam int N_STATS = 3;

    state_t                  state_reg, state_next;
    logic [CMD_WIDTH-1:0]    cmd_reg;
    logic [3:0]              tag_reg;
    logic [23:0]             psn_reg;
    logic                    overrun_reg;

    logic                    opcode_ok, length_ok, psn_ok, accept;
    logic [31:0]             saddr;
    logic [CMD_BTT_WIDTH-1:0] btt;
    logic                    cmd_hs, data_last, drop_last, sts_hs, sts_ok;
    logic [N_STATS-1:0]      stat_inc;
    logic [15:0]             stat_cnt [N_STATS];
    logic                    unused_ok;

    assign opcode_ok = (rdma_opcode == OP_WRITE_TEST) || (rdma_opcode == OP_WRITE_ONLY);
    assign length_ok = (rdma_length != 32'd0) && ((rdma_length >> BTT_WIDTH) == 32'd0);
`ifdef RX_PSN_CHECK_EN
    assign psn_ok    = (rdma_psn == psn_reg);
`else
    assign psn_ok    = 1'b1;
`endif
    assign accept    = opcode_ok && length_ok && psn_ok;

    // Address arithmetic wraps at 4 GiB by design
    assign saddr = rdma_remote_addr + {16'h0, fragment_offset};
    assign btt   = CMD_BTT_WIDTH'(rdma_length[BTT_WIDTH-1:0]);

    assign cmd_hs    = (state_reg == CMD)  && m_axis_cmd_tready;
    assign data_last = (state_reg == DATA) && s_axis_tvalid && m_axis_tready && s_axis_tlast;
    assign drop_last = (state_reg == DROP) && s_axis_tvalid && s_axis_tlast;
    assign sts_hs    = (state_reg == STS)  && s_axis_sts_tvalid;
    assign sts_ok    = sts_is_ok(s_axis_sts_tdata);

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (header_valid) state_next = accept ? CMD : DROP;
            CMD:  if (m_axis_cmd_tready) state_next = DATA;
            DATA: if (data_last) state_next = STS;
            DROP: if (drop_last) state_next = IDLE;
            STS:  if (s_axis_sts_tvalid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy              = (state_reg != IDLE);
        m_axis_cmd_tvalid = (state_reg == CMD);
        s_axis_sts_tready = (state_reg == STS);
        s_axis_tready     = 1'b0;
        m_axis_tvalid     = 1'b0;
        case (state_reg)
            DATA: begin
                s_axis_tready = m_axis_tready;
                m_axis_tvalid = s_axis_tvalid;
            end
            DROP: s_axis_tready = 1'b1;
            default: ;
        endcase
    end

    // Command is captured with the header, so it is stable for the whole CMD wait
    always_ff @(posedge aclk) begin
        if (areset) begin
            cmd_reg     <= '0;
            tag_reg     <= 4'd0;
            psn_reg     <= 24'd0;
            overrun_reg <= 1'b0;
        end else begin
            if ((state_reg == IDLE) && header_valid) begin
                cmd_reg <= s2mm_cmd(tag_reg, saddr, btt);
            end
            if (cmd_hs) begin
                tag_reg <= tag_reg + 4'd1;
            end
            if (sts_hs && sts_ok) begin
                psn_reg <= psn_reg + 24'd1;
            end
            if (header_valid && (state_reg != IDLE)) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    assign stat_inc[0] = sts_hs && sts_ok;
    assign stat_inc[1] = drop_last;
    assign stat_inc[2] = sts_hs && !sts_ok;

    genvar gi;
    generate
        for (gi = 0; gi < N_STATS; gi++) begin : g_stat
            rx_sat_counter #(.WIDTH(16)) u_cnt (
                .aclk   (aclk),
                .areset (areset),
                .inc    (stat_inc[gi]),
                .count  (stat_cnt[gi])
            );
        end
    endgenerate

    assign pkt_ok_cnt   = stat_cnt[0];
    assign pkt_drop_cnt = stat_cnt[1];
    assign dma_err_cnt  = stat_cnt[2];

    assign m_axis_tdata     = s_axis_tdata;
    assign m_axis_tkeep     = s_axis_tkeep;
    assign m_axis_tlast     = s_axis_tlast;
    assign m_axis_cmd_tdata = cmd_reg;
    assign expected_psn     = psn_reg;
    assign hdr_overrun      = overrun_reg;

    // Status tag echo and (without the PSN check) the header PSN are not needed
    assign unused_ok = ^{s_axis_sts_tdata[STS_TAG_LSB +: 4], rdma_psn};

endmodule
